// File: rtl/adder_sum_accumulator_if.sv
// Handshake bundle between the upstream 4-bit adder, the batch accumulator and the result consumer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the sum side, acc_valid/acc_ready on the result side.
// Ports: sum_in/in_valid/clear/acc_ready into the block; in_ready/acc_out/overflow/acc_valid/sample_cnt out of it.
interface adder_sum_accumulator_if #(
    parameter int ACC_W = 8,
    parameter int BATCH = 16
);
    localparam int CNT_W = $clog2(BATCH);

    logic [4:0]       sum_in;
    logic             in_valid;
    logic             in_ready;
    logic             clear;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic             acc_valid;
    logic             acc_ready;
    logic [CNT_W-1:0] sample_cnt;

    // Producer/consumer side (drives sums and consumes results).
    modport master (
        output sum_in, in_valid, clear, acc_ready,
        input  in_ready, acc_out, overflow, acc_valid, sample_cnt
    );

    // Accumulator side.
    modport slave (
        input  sum_in, in_valid, clear, acc_ready,
        output in_ready, acc_out, overflow, acc_valid, sample_cnt
    );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Accumulates BATCH 5-bit adder sums into an ACC_W-bit total with sticky overflow (saturate or wrap).
// Latency: result valid 1 cycle after the BATCH-th accepted sum.
// Backpressure: in_ready drops for the whole DRAIN phase until acc_valid && acc_ready; both flags come from state only.
// Ports: clk, rst (async, active-high); bus (slave modport) carries sum/result handshakes, clear and sample_cnt.
module adder_sum_accumulator #(
    parameter int ACC_W    = 8,
    parameter int BATCH    = 16,
    parameter int SATURATE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    adder_sum_accumulator_if.slave   bus
);
    localparam int CNT_W = $clog2(BATCH);

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_ovf_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [ACC_W:0]   w_sum;

    // One extra bit so the carry out of the accumulator is visible.
    assign w_sum = {1'b0, r_acc} + {{(ACC_W-4){1'b0}}, bus.sum_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        w_cnt_nxt   = r_cnt;

        if (bus.clear) begin
            // Abort wins over both accept and result handshake.
            w_state_nxt = ACCUM;
            w_acc_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        if (w_sum[ACC_W]) begin
                            w_ovf_nxt = 1'b1;
                            // A saturated acc re-carries on any non-zero sum, so it stays clamped.
                            w_acc_nxt = (SATURATE != 0) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
                        end else begin
                            w_acc_nxt = w_sum[ACC_W-1:0];
                        end
                        // Power-of-two BATCH: the counter wraps to 0 on the last sum by itself.
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(BATCH - 1)) begin
                            w_state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.acc_ready) begin
                        w_state_nxt = ACCUM;
                        w_acc_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end
                default: w_state_nxt = ACCUM;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == ACCUM);
    assign bus.acc_valid  = (r_state == DRAIN);
    assign bus.acc_out    = r_acc;
    assign bus.overflow   = r_ovf;
    assign bus.sample_cnt = r_cnt;
endmodule

// File: tb/tb_adder_sum_accumulator.sv
module tb_adder_sum_accumulator;
    localparam int BATCH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] sum_in = '0;
    logic       in_valid = 1'b0;
    logic       clear = 1'b0;
    logic       acc_ready = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: plain integer batch total; both output flavours derive from it.
    int m_total = 0;
    int m_cnt   = 0;
    bit m_drain = 1'b0;

    always #5 clk = ~clk;

    adder_sum_accumulator_if #(.ACC_W(8), .BATCH(BATCH)) if_sat ();
    adder_sum_accumulator_if #(.ACC_W(8), .BATCH(BATCH)) if_wrap ();

    assign if_sat.sum_in     = sum_in;
    assign if_sat.in_valid   = in_valid;
    assign if_sat.clear      = clear;
    assign if_sat.acc_ready  = acc_ready;
    assign if_wrap.sum_in    = sum_in;
    assign if_wrap.in_valid  = in_valid;
    assign if_wrap.clear     = clear;
    assign if_wrap.acc_ready = acc_ready;

    adder_sum_accumulator #(.ACC_W(8), .BATCH(BATCH), .SATURATE(1)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (if_sat.slave)
    );

    adder_sum_accumulator #(.ACC_W(8), .BATCH(BATCH), .SATURATE(0)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (if_wrap.slave)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int exp_sat();
        return (m_total > 255) ? 255 : m_total;
    endfunction

    function automatic int exp_wrap();
        return m_total % 256;
    endfunction

    // Behavioural model advances on the same edges the DUTs see.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_total = 0; m_cnt = 0; m_drain = 1'b0;
        end else if (clear) begin
            m_total = 0; m_cnt = 0; m_drain = 1'b0;
        end else if (!m_drain) begin
            if (in_valid) begin
                m_total = m_total + int'(sum_in);
                m_cnt   = m_cnt + 1;
                if (m_cnt == BATCH) begin
                    m_cnt   = 0;
                    m_drain = 1'b1;
                end
            end
        end else if (acc_ready) begin
            m_total = 0; m_cnt = 0; m_drain = 1'b0;
        end
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        chk("sat_in_ready",  int'(if_sat.in_ready),   int'(!m_drain));
        chk("sat_acc_valid", int'(if_sat.acc_valid),  int'(m_drain));
        chk("sat_cnt",       int'(if_sat.sample_cnt), m_cnt);
        chk("sat_acc",       int'(if_sat.acc_out),    exp_sat());
        chk("sat_ovf",       int'(if_sat.overflow),   int'(m_total > 255));
        chk("wrap_in_ready", int'(if_wrap.in_ready),  int'(!m_drain));
        chk("wrap_acc_valid",int'(if_wrap.acc_valid), int'(m_drain));
        chk("wrap_cnt",      int'(if_wrap.sample_cnt),m_cnt);
        chk("wrap_acc",      int'(if_wrap.acc_out),   exp_wrap());
        chk("wrap_ovf",      int'(if_wrap.overflow),  int'(m_total > 255));
    end

    // Offer one sum and hold it until the edge that accepts it.
    task automatic send(input logic [4:0] v);
        int t = 0;
        sum_in   = v;
        in_valid = 1'b1;
        while (!if_sat.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            n_chk++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state while rst is held.
        #1;
        chk("rst_in_ready",  int'(if_sat.in_ready),  1);
        chk("rst_acc_valid", int'(if_sat.acc_valid), 0);
        chk("rst_acc",       int'(if_sat.acc_out),   0);
        chk("rst_cnt",       int'(if_sat.sample_cnt),0);
        cycle(); cycle();
        rst = 1'b0;

        // Basic batch: 16 x 1 with the consumer always ready.
        acc_ready = 1'b1;
        for (int i = 0; i < BATCH; i++) send(5'd1);
        chk("basic_valid", int'(if_sat.acc_valid), 1);
        chk("basic_acc",   int'(if_sat.acc_out),   16);
        chk("basic_ovf",   int'(if_sat.overflow),  0);
        chk("basic_wacc",  int'(if_wrap.acc_out),  16);
        cycle();
        chk("basic_ready_back", int'(if_sat.in_ready), 1);

        // Overflow: 16 x 31 = 496, then hold the result under backpressure.
        acc_ready = 1'b0;
        for (int i = 0; i < BATCH; i++) send(5'd31);
        chk("ovf_sat_acc",  int'(if_sat.acc_out),  255);
        chk("ovf_sat_flag", int'(if_sat.overflow), 1);
        chk("ovf_wrap_acc", int'(if_wrap.acc_out), 240);
        chk("ovf_wrap_flag",int'(if_wrap.overflow),1);
        sum_in = 5'd7; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_in_ready", int'(if_sat.in_ready),   0);
            chk("bp_acc",      int'(if_sat.acc_out),    255);
            chk("bp_cnt",      int'(if_sat.sample_cnt), 0);
        end
        acc_ready = 1'b1;
        cycle();
        chk("bp_release_ready", int'(if_sat.in_ready), 1);
        chk("bp_release_acc",   int'(if_sat.acc_out),  0);
        cycle();
        chk("bp_next_acc", int'(if_sat.acc_out),    7);
        chk("bp_next_cnt", int'(if_sat.sample_cnt), 1);
        in_valid = 1'b0;
        clear = 1'b1; cycle(); clear = 1'b0;

        // Gaps then clear with a sum on offer.
        for (int i = 0; i < 7; i++) begin
            send(5'd5);
            cycle();
        end
        chk("gap_cnt", int'(if_sat.sample_cnt), 7);
        chk("gap_acc", int'(if_sat.acc_out),    35);
        clear = 1'b1; sum_in = 5'd5; in_valid = 1'b1;
        cycle();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_cnt", int'(if_sat.sample_cnt), 0);
        chk("clr_acc", int'(if_sat.acc_out),    0);
        acc_ready = 1'b0;
        for (int i = 0; i < BATCH; i++) send(5'd2);
        chk("clr_batch_acc", int'(if_sat.acc_out), 32);
        acc_ready = 1'b1;
        cycle();

        // Asynchronous reset in the middle of a DRAIN holding 200.
        acc_ready = 1'b0;
        for (int i = 0; i < BATCH; i++) send((i < 8) ? 5'd25 : 5'd0);
        chk("pre_rst_acc", int'(if_sat.acc_out), 200);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_valid",    int'(if_sat.acc_valid), 0);
        chk("arst_acc",      int'(if_sat.acc_out),   0);
        chk("arst_ovf",      int'(if_sat.overflow),  0);
        chk("arst_in_ready", int'(if_sat.in_ready),  1);
        cycle(); cycle();
        rst = 1'b0;
        acc_ready = 1'b1;
        for (int i = 0; i < BATCH; i++) send(5'd1);
        chk("post_rst_acc", int'(if_sat.acc_out), 16);

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            cycle();
            in_valid  = ($urandom_range(3) != 0);
            sum_in    = 5'($urandom_range(31));
            acc_ready = ($urandom_range(2) != 0);
            clear     = ($urandom_range(59) == 0);
        end
        in_valid = 1'b0; clear = 1'b0;
        cycle(); cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
